// File: rtl/riscv_alu_pkg.sv
// Shared decode constants and the internal op encoding for the logical/shift execute unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_alu_pkg;

   // Major opcodes handled by this unit
   localparam logic [6:0] OPCODE_R = 7'b0110011;
   localparam logic [6:0] OPCODE_I = 7'b0010011;

   // func3 encodings within OP / OP-IMM
   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   // Internal operation carried down the pipe after decode
   typedef enum logic [3:0] {
      OP_AND,
      OP_OR,
      OP_XOR,
      OP_SLL,
      OP_SRL,
      OP_SRA,
      OP_ANDN,
      OP_ORN,
      OP_XNOR,
      OP_ILL
   } alu_op_e;

   // True when the decoded op is not executable by this unit
   function automatic logic op_is_illegal(input alu_op_e op);
      return (op == OP_ILL);
   endfunction

endpackage

// File: rtl/logic_shift_core.sv
// Combinational logical/shift datapath: (op, a, b) -> XLEN-bit result; illegal op yields zero.
// Latency: 0 cycles (pure combinational, registered by the caller).
// Backpressure: none; the caller decides when the result is captured.
module logic_shift_core
   import riscv_alu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  alu_op_e          op,
   input  logic [XLEN-1:0]  a,
   input  logic [XLEN-1:0]  b,
   output logic [XLEN-1:0]  y
);

   localparam int SHAMT_W = $clog2(XLEN);

   // Only the low log2(XLEN) bits of the second operand select the shift distance
   logic [SHAMT_W-1:0] shamt;
   assign shamt = b[SHAMT_W-1:0];

   // Result select; anything unrecognised (OP_ILL) produces zero
   always_comb begin
      y = '0;
      case (op)
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_XOR:  y = a ^ b;
         OP_SLL:  y = a << shamt;
         OP_SRL:  y = a >> shamt;
         OP_SRA:  y = $signed(a) >>> shamt;
         OP_ANDN: y = a & ~b;
         OP_ORN:  y = a | ~b;
         OP_XNOR: y = ~(a ^ b);
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/logical_alu_pipe.sv
// Pipelined RV32/RV64 logical/shift execute unit: decode -> S1 register -> compute -> S2 register.
// Latency: 2 cycles from accept to out_valid; throughput 1 op/cycle.
// Backpressure: valid/ready; S2 holds while out_ready=0, in_ready drops once S1 and S2 are both full.
// Build option: define LOGICAL_ALU_ZBB_EN to decode R-type f7b5=1 XOR/OR/AND as XNOR/ORN/ANDN.
module logical_alu_pipe
   import riscv_alu_pkg::*;
#(
   parameter int XLEN = 32   // 32 or 64 only
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [XLEN-1:0]  op1,
   input  logic [XLEN-1:0]  op2,
   input  logic [6:0]       opcode,
   input  logic [2:0]       func3,
   input  logic             f7b5,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  result,
   output logic             illegal
);

   // Ops selected by R-type f7b5=1 in the logical func3 slots
`ifdef LOGICAL_ALU_ZBB_EN
   localparam alu_op_e ALT_XOR = OP_XNOR;
   localparam alu_op_e ALT_OR  = OP_ORN;
   localparam alu_op_e ALT_AND = OP_ANDN;
`else
   localparam alu_op_e ALT_XOR = OP_ILL;
   localparam alu_op_e ALT_OR  = OP_ILL;
   localparam alu_op_e ALT_AND = OP_ILL;
`endif

   // Stage 1: decoded op + operands
   logic             s1_valid_q, s1_valid_d;
   alu_op_e          s1_op_q,    s1_op_d;
   logic [XLEN-1:0]  s1_a_q,     s1_a_d;
   logic [XLEN-1:0]  s1_b_q,     s1_b_d;

   // Stage 2: computed result
   logic             s2_valid_q,   s2_valid_d;
   logic [XLEN-1:0]  s2_result_q,  s2_result_d;
   logic             s2_illegal_q, s2_illegal_d;

   alu_op_e          dec_op;
   logic [XLEN-1:0]  core_y;
   logic             s2_free;
   logic             s1_adv;
   logic             accept;

   // Handshake: S2 can take a new op when empty or being drained this cycle
   always_comb begin
      s2_free  = !s2_valid_q || out_ready;
      s1_adv   = s1_valid_q && s2_free;
      in_ready = !s1_valid_q || s2_free;
      accept   = in_valid && in_ready;
   end

   // Decode opcode/func3/f7b5 into the internal op ahead of S1
   always_comb begin
      logic is_r;
      logic is_i;
      is_r   = (opcode == OPCODE_R);
      is_i   = (opcode == OPCODE_I);
      dec_op = OP_ILL;
      if (is_r || is_i) begin
         case (func3)
            F3_XOR:  dec_op = (is_i || !f7b5) ? OP_XOR : ALT_XOR;
            F3_OR:   dec_op = (is_i || !f7b5) ? OP_OR  : ALT_OR;
            F3_AND:  dec_op = (is_i || !f7b5) ? OP_AND : ALT_AND;
            F3_SLL:  dec_op = f7b5 ? OP_ILL : OP_SLL;
            F3_SR:   dec_op = f7b5 ? OP_SRA : OP_SRL;
            // ADD/SUB, SLT, SLTU belong to the arithmetic/compare unit
            default: dec_op = OP_ILL;
         endcase
      end
   end

   // S2 compute from the S1 register contents
   logic_shift_core #(
      .XLEN (XLEN)
   ) u_core (
      .op (s1_op_q),
      .a  (s1_a_q),
      .b  (s1_b_q),
      .y  (core_y)
   );

   // S1 next state: load on accept, empty on advance, cleared by flush
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_op_d    = s1_op_q;
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      if (accept) begin
         s1_valid_d = 1'b1;
         s1_op_d    = dec_op;
         s1_a_d     = op1;
         s1_b_d     = op2;
      end else if (s1_adv) begin
         s1_valid_d = 1'b0;
      end
      if (flush) begin
         s1_valid_d = 1'b0;
      end
   end

   // S2 next state: capture on advance, hold while stalled, cleared by flush
   always_comb begin
      s2_valid_d   = s2_valid_q;
      s2_result_d  = s2_result_q;
      s2_illegal_d = s2_illegal_q;
      if (s1_adv) begin
         s2_valid_d   = 1'b1;
         s2_result_d  = core_y;
         s2_illegal_d = op_is_illegal(s1_op_q);
      end else if (s2_free) begin
         s2_valid_d = 1'b0;
      end
      if (flush) begin
         s2_valid_d = 1'b0;
      end
   end

   // Pipeline registers; reset discards everything in flight and dominates flush
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q   <= 1'b0;
         s1_op_q      <= OP_ILL;
         s1_a_q       <= '0;
         s1_b_q       <= '0;
         s2_valid_q   <= 1'b0;
         s2_result_q  <= '0;
         s2_illegal_q <= 1'b0;
      end else begin
         s1_valid_q   <= s1_valid_d;
         s1_op_q      <= s1_op_d;
         s1_a_q       <= s1_a_d;
         s1_b_q       <= s1_b_d;
         s2_valid_q   <= s2_valid_d;
         s2_result_q  <= s2_result_d;
         s2_illegal_q <= s2_illegal_d;
      end
   end

   assign out_valid = s2_valid_q;
   assign result    = s2_result_q;
   assign illegal   = s2_illegal_q;

endmodule
